// File: rtl/amm_csr_pkg.sv
// Shared definitions for the Avalon-MM CSR slave that commands the SDRAM
// transfer master.
//   - ADDR_*  : word offsets of the eight registers on the slave port
//   - CTRL_*  : bit positions inside the CTRL register
//   - STAT_*  : bit positions inside the STATUS register
//   - ctrl_reg_t : the persistent (read/write) part of CTRL
//   - ctrl_readback / pack_status : build the 32-bit read images
package amm_csr_pkg;

  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_STATUS    = 3'd1;
  localparam logic [2:0] ADDR_WR_BASE   = 3'd2;
  localparam logic [2:0] ADDR_WR_LEN    = 3'd3;
  localparam logic [2:0] ADDR_RD_BASE   = 3'd4;
  localparam logic [2:0] ADDR_RD_LEN    = 3'd5;
  localparam logic [2:0] ADDR_FIFO_DATA = 3'd6;
  localparam logic [2:0] ADDR_DISPLAY   = 3'd7;

  localparam int CTRL_WR_GO    = 0;
  localparam int CTRL_RD_GO    = 1;
  localparam int CTRL_WR_FIXED = 2;
  localparam int CTRL_RD_FIXED = 3;
  localparam int CTRL_IRQ_EN   = 4;

  localparam int STAT_WR_BUSY   = 0;
  localparam int STAT_RD_BUSY   = 1;
  localparam int STAT_WR_DONE   = 2;
  localparam int STAT_RD_DONE   = 3;
  localparam int STAT_FIFO_FULL = 4;
  localparam int STAT_OVERFLOW  = 5;
  localparam int STAT_COUNT_LSB = 8;

  typedef struct packed {
    logic irq_en;
    logic rd_fixed;
    logic wr_fixed;
  } ctrl_reg_t;

  // The go bits are strobes and have no storage, so they always read as 0.
  function automatic logic [31:0] ctrl_readback(input ctrl_reg_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_WR_FIXED] = c.wr_fixed;
    w[CTRL_RD_FIXED] = c.rd_fixed;
    w[CTRL_IRQ_EN]   = c.irq_en;
    return w;
  endfunction

  function automatic logic [31:0] pack_status(
    input logic       wr_busy,
    input logic       rd_busy,
    input logic       wr_done,
    input logic       rd_done,
    input logic       fifo_full,
    input logic       overflow,
    input logic [7:0] count
  );
    logic [31:0] w;
    w = '0;
    w[STAT_WR_BUSY]   = wr_busy;
    w[STAT_RD_BUSY]   = rd_busy;
    w[STAT_WR_DONE]   = wr_done;
    w[STAT_RD_DONE]   = rd_done;
    w[STAT_FIFO_FULL] = fifo_full;
    w[STAT_OVERFLOW]  = overflow;
    w[STAT_COUNT_LSB +: 8] = count;
    return w;
  endfunction

endpackage

// File: rtl/amm_csr_slave_if.sv
// Avalon-MM slave bus bundle between the Qsys interconnect and the CSR block.
//   avs_address       word offset (8 registers)
//   avs_read/write    transfer strobes
//   avs_writedata     write data, avs_byteenable byte lanes
//   avs_readdata      registered read data, valid with avs_readdatavalid
//   avs_waitrequest   stall (only asserted while the slave is in reset)
// The slave modport is used by amm_csr_slave, master by the interconnect side.
interface amm_csr_slave_if #(
  parameter int DATAWIDTH = 32
);

  logic [2:0]             avs_address;
  logic                   avs_read;
  logic                   avs_write;
  logic [DATAWIDTH-1:0]   avs_writedata;
  logic [DATAWIDTH/8-1:0] avs_byteenable;
  logic [DATAWIDTH-1:0]   avs_readdata;
  logic                   avs_readdatavalid;
  logic                   avs_waitrequest;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_readdatavalid, avs_waitrequest
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_readdatavalid, avs_waitrequest
  );

endinterface

// File: rtl/sync_fifo_sa.sv
// Single-clock show-ahead FIFO: the head word is presented on data_o without
// needing a pop, and a pop advances to the next word on the following cycle.
//   clk_i, reset_n_i   clock, synchronous active-low reset (empties the FIFO)
//   push_i, data_i     write strobe and word
//   pop_i              consume the head word
//   data_o             head word (0 while empty)
//   count_o            number of stored words
//   full_o, empty_o    occupancy flags
//   drop_o             a push was discarded this cycle because the FIFO was full
module sync_fifo_sa
  import amm_csr_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       push_i,
  input  logic [DATAWIDTH-1:0]       data_i,
  input  logic                       pop_i,
  output logic [DATAWIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       drop_o
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]      count_q, count_d;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == CNTW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop on an empty FIFO is ignored. A push into a full FIFO only lands
  // when a pop frees the head slot in the same cycle; otherwise it is dropped.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~do_push;

  // Pointer and occupancy next-state; DEPTH is a power of two so the
  // pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTRW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTRW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNTW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNTW'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are never observable while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/amm_csr_slave.sv
// Avalon-MM CSR slave through which the PCIe host commands the SDRAM transfer
// master: base/length registers, go pulses, sticky done/overflow status,
// a host-to-user data FIFO, the 7-segment display word and an interrupt.
//   clk_i, reset_n_i            clock, synchronous active-low reset
//   avs                         Avalon-MM slave port (amm_csr_slave_if.slave)
//   ctl_wr_go_o / ctl_rd_go_o   one-cycle start pulses to the transfer master
//   ctl_*_fixed_location_o      CTRL fixed-address bits
//   ctl_*_addr_base_o/length_o  transfer base and length registers
//   ctl_wr_done_i / ctl_rd_done_i completion pulses from the transfer master
//   usr_wr_buffer_i             pop strobe for the host-to-user FIFO
//   usr_wr_buffer_data_o        FIFO head word (show-ahead)
//   usr_wr_buffer_nonempty_o    FIFO holds at least one word
//   display_data_o              DISPLAY register
//   irq_o                       level interrupt
module amm_csr_slave
  import amm_csr_pkg::*;
#(
  parameter int ADDRESSWIDTH = 28,
  parameter int DATAWIDTH    = 32,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  amm_csr_slave_if.slave          avs,
  output logic                    ctl_wr_go_o,
  output logic                    ctl_rd_go_o,
  output logic                    ctl_wr_fixed_location_o,
  output logic                    ctl_rd_fixed_location_o,
  output logic [ADDRESSWIDTH-1:0] ctl_wr_addr_base_o,
  output logic [ADDRESSWIDTH-1:0] ctl_wr_length_o,
  output logic [ADDRESSWIDTH-1:0] ctl_rd_addr_base_o,
  output logic [ADDRESSWIDTH-1:0] ctl_rd_length_o,
  input  logic                    ctl_wr_done_i,
  input  logic                    ctl_rd_done_i,
  input  logic                    usr_wr_buffer_i,
  output logic [DATAWIDTH-1:0]    usr_wr_buffer_data_o,
  output logic                    usr_wr_buffer_nonempty_o,
  output logic [31:0]             display_data_o,
  output logic                    irq_o
);

  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  ctrl_reg_t             ctrl_q, ctrl_d;
  logic                  wr_busy_q, wr_busy_d, rd_busy_q, rd_busy_d;
  logic                  wr_done_q, wr_done_d, rd_done_q, rd_done_d;
  logic                  overflow_q, overflow_d;
  logic                  wr_go_q, wr_go_d, rd_go_q, rd_go_d;
  logic [ADDRESSWIDTH-1:0] wr_base_q, wr_base_d, wr_len_q, wr_len_d;
  logic [ADDRESSWIDTH-1:0] rd_base_q, rd_base_d, rd_len_q, rd_len_d;
  logic [31:0]           display_q, display_d;
  logic [DATAWIDTH-1:0]  readdata_q, readdata_d;
  logic                  readdatavalid_q, readdatavalid_d;
  logic                  waitrequest_q;

  logic                  wr_en, rd_en;
  logic [DATAWIDTH-1:0]  wdata;
  logic [DATAWIDTH-1:0]  reg_image;
  logic [DATAWIDTH-1:0]  merged;
  logic                  wr_start, wr_zero, rd_start, rd_zero;
  logic                  clr_wr_done, clr_rd_done, clr_overflow;
  logic                  fifo_push, fifo_full, fifo_empty, fifo_drop;
  logic [CNTW-1:0]       fifo_count;

  // Lanes with byteenable set take the new data; the rest keep the old value.
  function automatic logic [DATAWIDTH-1:0] be_merge(
    input logic [DATAWIDTH-1:0]   cur,
    input logic [DATAWIDTH-1:0]   nxt,
    input logic [DATAWIDTH/8-1:0] be
  );
    logic [DATAWIDTH-1:0] res;
    res = cur;
    for (int b = 0; b < DATAWIDTH/8; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = nxt[8*b +: 8];
      end
    end
    return res;
  endfunction

  // Transfers are only accepted once waitrequest has dropped. A write wins
  // over a simultaneous read, and that read then gets no response.
  assign wr_en = avs.avs_write & ~waitrequest_q;
  assign rd_en = avs.avs_read & ~avs.avs_write & ~waitrequest_q;
  assign wdata = avs.avs_writedata;

  sync_fifo_sa #(
    .DATAWIDTH(DATAWIDTH),
    .DEPTH    (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .push_i   (fifo_push),
    .data_i   (wdata),
    .pop_i    (usr_wr_buffer_i),
    .data_o   (usr_wr_buffer_data_o),
    .count_o  (fifo_count),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .drop_o   (fifo_drop)
  );

  // Read image of the addressed register, built from current (pre-update)
  // state. It doubles as the "old value" for byteenable merges on writes.
  always_comb begin
    reg_image = '0;
    case (avs.avs_address)
      ADDR_CTRL:      reg_image = DATAWIDTH'(ctrl_readback(ctrl_q));
      ADDR_STATUS:    reg_image = DATAWIDTH'(pack_status(wr_busy_q, rd_busy_q,
                                    wr_done_q, rd_done_q, fifo_full,
                                    overflow_q, 8'(fifo_count)));
      ADDR_WR_BASE:   reg_image = DATAWIDTH'(wr_base_q);
      ADDR_WR_LEN:    reg_image = DATAWIDTH'(wr_len_q);
      ADDR_RD_BASE:   reg_image = DATAWIDTH'(rd_base_q);
      ADDR_RD_LEN:    reg_image = DATAWIDTH'(rd_len_q);
      ADDR_FIFO_DATA: reg_image = '0;
      ADDR_DISPLAY:   reg_image = DATAWIDTH'(display_q);
      default:        reg_image = '0;
    endcase
  end

  assign merged = be_merge(reg_image, wdata, avs.avs_byteenable);

  // Go requests: a zero length completes immediately without a pulse, and a
  // request while the channel is busy is dropped.
  assign wr_start = wr_en && (avs.avs_address == ADDR_CTRL) && wdata[CTRL_WR_GO]
                    && !wr_busy_q && (wr_len_q != '0);
  assign wr_zero  = wr_en && (avs.avs_address == ADDR_CTRL) && wdata[CTRL_WR_GO]
                    && !wr_busy_q && (wr_len_q == '0);
  assign rd_start = wr_en && (avs.avs_address == ADDR_CTRL) && wdata[CTRL_RD_GO]
                    && !rd_busy_q && (rd_len_q != '0);
  assign rd_zero  = wr_en && (avs.avs_address == ADDR_CTRL) && wdata[CTRL_RD_GO]
                    && !rd_busy_q && (rd_len_q == '0);

  assign clr_wr_done  = wr_en && (avs.avs_address == ADDR_STATUS) && wdata[STAT_WR_DONE];
  assign clr_rd_done  = wr_en && (avs.avs_address == ADDR_STATUS) && wdata[STAT_RD_DONE];
  assign clr_overflow = wr_en && (avs.avs_address == ADDR_STATUS) && wdata[STAT_OVERFLOW];
  assign fifo_push    = wr_en && (avs.avs_address == ADDR_FIFO_DATA);

  // Register next-state. Sticky bits are cleared first and then set, so a
  // completion or overflow in the same cycle as its W1C is never lost.
  // Transfer registers are frozen while their channel is busy.
  always_comb begin
    ctrl_d     = ctrl_q;
    wr_base_d  = wr_base_q;
    wr_len_d   = wr_len_q;
    rd_base_d  = rd_base_q;
    rd_len_d   = rd_len_q;
    display_d  = display_q;
    wr_busy_d  = wr_busy_q;
    rd_busy_d  = rd_busy_q;
    wr_done_d  = wr_done_q;
    rd_done_d  = rd_done_q;
    overflow_d = overflow_q;
    wr_go_d    = wr_start;
    rd_go_d    = rd_start;

    if (wr_en) begin
      case (avs.avs_address)
        ADDR_CTRL: begin
          ctrl_d.wr_fixed = wdata[CTRL_WR_FIXED];
          ctrl_d.rd_fixed = wdata[CTRL_RD_FIXED];
          ctrl_d.irq_en   = wdata[CTRL_IRQ_EN];
        end
        ADDR_WR_BASE: if (!wr_busy_q) wr_base_d = ADDRESSWIDTH'(merged);
        ADDR_WR_LEN:  if (!wr_busy_q) wr_len_d  = ADDRESSWIDTH'(merged);
        ADDR_RD_BASE: if (!rd_busy_q) rd_base_d = ADDRESSWIDTH'(merged);
        ADDR_RD_LEN:  if (!rd_busy_q) rd_len_d  = ADDRESSWIDTH'(merged);
        ADDR_DISPLAY: display_d = 32'(merged);
        default: ;
      endcase
    end

    if (ctl_wr_done_i) wr_busy_d = 1'b0;
    if (wr_start)      wr_busy_d = 1'b1;
    if (ctl_rd_done_i) rd_busy_d = 1'b0;
    if (rd_start)      rd_busy_d = 1'b1;

    if (clr_wr_done)             wr_done_d  = 1'b0;
    if (ctl_wr_done_i || wr_zero) wr_done_d  = 1'b1;
    if (clr_rd_done)             rd_done_d  = 1'b0;
    if (ctl_rd_done_i || rd_zero) rd_done_d  = 1'b1;
    if (clr_overflow)            overflow_d = 1'b0;
    if (fifo_drop)               overflow_d = 1'b1;
  end

  // Read response path: one cycle of latency, data zeroed when idle.
  always_comb begin
    readdatavalid_d = rd_en;
    readdata_d      = rd_en ? reg_image : '0;
  end

  // State registers. waitrequest is held high through reset and drops on the
  // first clock edge that sees reset_n released.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      ctrl_q          <= '0;
      wr_base_q       <= '0;
      wr_len_q        <= '0;
      rd_base_q       <= '0;
      rd_len_q        <= '0;
      display_q       <= '0;
      wr_busy_q       <= 1'b0;
      rd_busy_q       <= 1'b0;
      wr_done_q       <= 1'b0;
      rd_done_q       <= 1'b0;
      overflow_q      <= 1'b0;
      wr_go_q         <= 1'b0;
      rd_go_q         <= 1'b0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      waitrequest_q   <= 1'b1;
    end else begin
      ctrl_q          <= ctrl_d;
      wr_base_q       <= wr_base_d;
      wr_len_q        <= wr_len_d;
      rd_base_q       <= rd_base_d;
      rd_len_q        <= rd_len_d;
      display_q       <= display_d;
      wr_busy_q       <= wr_busy_d;
      rd_busy_q       <= rd_busy_d;
      wr_done_q       <= wr_done_d;
      rd_done_q       <= rd_done_d;
      overflow_q      <= overflow_d;
      wr_go_q         <= wr_go_d;
      rd_go_q         <= rd_go_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
      waitrequest_q   <= 1'b0;
    end
  end

  assign avs.avs_readdata      = readdata_q;
  assign avs.avs_readdatavalid = readdatavalid_q;
  assign avs.avs_waitrequest   = waitrequest_q;

  assign ctl_wr_go_o             = wr_go_q;
  assign ctl_rd_go_o             = rd_go_q;
  assign ctl_wr_fixed_location_o = ctrl_q.wr_fixed;
  assign ctl_rd_fixed_location_o = ctrl_q.rd_fixed;
  assign ctl_wr_addr_base_o      = wr_base_q;
  assign ctl_wr_length_o         = wr_len_q;
  assign ctl_rd_addr_base_o      = rd_base_q;
  assign ctl_rd_length_o         = rd_len_q;
  assign usr_wr_buffer_nonempty_o = ~fifo_empty;
  assign display_data_o          = display_q;
  assign irq_o = ctrl_q.irq_en & (wr_done_q | rd_done_q | overflow_q);

endmodule
